uart_sram_loader: RTL and testbench
===================================

Name: uart_sram_loader

Overview:
- Sequencer that drains the byte-packing UART receive FIFO (16-bit halfwords out) and writes each halfword into the 16-bit asynchronous SRAM at consecutive word addresses.
- Sits between the UART/FIFO path and the SRAM pins. It owns the SRAM bus while loading and releases it when finished.
- Accepts a start command with a base address and word count. Reports busy, done and a timeout error.

Parameters:
ADDR_W, 23, SRAM word-address width; also the width of base_addr, word_count and words_written.
WE_CYCLES, 4, cycles sram_we_n is held low per write (>=1).
TIMEOUT, 1000000, consecutive empty-FIFO cycles while waiting for data before abort (>=1).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  load request; sampled only in IDLE
base_addr  in  ADDR_W  first SRAM word address; captured on accepted start
word_count  in  ADDR_W  number of halfwords to write; captured on accepted start
fifo_empty  in  1  FIFO holds no complete halfword
fifo_dout  in  16  FIFO read data, valid the cycle after the fifo_rd pulse
fifo_rd  out  1  one-cycle read strobe to FIFO
sram_addr  out  ADDR_W  SRAM word address
sram_dq_out  out  16  write data to SRAM pins
sram_dq_oe  out  1  1 = drive sram_dq_out onto bidirectional pins
sram_ce_n  out  1  chip enable, active-low
sram_we_n  out  1  write enable, active-low
sram_oe_n  out  1  output enable, active-low; held 1 while busy
sram_ub_n  out  1  upper byte enable, active-low
sram_lb_n  out  1  lower byte enable, active-low
busy  out  1  load in progress; SRAM bus owned by this block
done  out  1  one-cycle pulse at end of load (normal or abort)
err  out  1  sticky timeout flag; cleared on next accepted start
words_written  out  ADDR_W  halfwords committed in the current or last load

Behaviour:
- All outputs registered.
- Reset values:
  - fifo_rd=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_ub_n=1, sram_lb_n=1.
  - sram_addr=0, sram_dq_out=0.
  - busy=0, done=0, err=0, words_written=0.
  - State = IDLE.
- Reset mid-operation: the strobes go inactive on that same edge. No partial write completes, and the FIFO is not touched afterwards.
- States: IDLE, WAIT_DATA, FETCH, CAPTURE, SETUP, WRITE, HOLD, FINISH.
- IDLE:
  - On start=1: capture base_addr into sram_addr and word_count into the remaining count; clear words_written and err; set busy=1.
  - If word_count==0, go to FINISH; otherwise go to WAIT_DATA.
- WAIT_DATA:
  - fifo_empty=0: go to FETCH and clear the timeout counter.
  - fifo_empty=1: increment the timeout counter. When it reaches TIMEOUT, set err=1 and go to FINISH.
- FETCH: fifo_rd=1 for exactly this cycle; go to CAPTURE.
- CAPTURE: latch fifo_dout into sram_dq_out; go to SETUP.
- SETUP (1 cycle): sram_ce_n=0, ub_n=0, lb_n=0, sram_dq_oe=1, sram_we_n=1. Address and data are stable.
- WRITE (WE_CYCLES cycles): sram_we_n=0. Address, data, CE and byte enables are unchanged.
- HOLD (1 cycle):
  - sram_we_n=1; data still driven.
  - Then sram_addr+1 (wraps modulo 2^ADDR_W), words_written+1, remaining-1.
  - If remaining is now 0, go to FINISH; else go to WAIT_DATA.
- FINISH (1 cycle):
  - done=1.
  - sram_ce_n, ub_n and lb_n return to 1; sram_dq_oe=0.
  - busy=0 from the next cycle; return to IDLE.
- Throughput with data always available: WE_CYCLES+5 cycles per halfword (9 by default).
- fifo_rd is asserted at most once per halfword and never while fifo_empty=1.
- start while busy is ignored. The captured base_addr and word_count are unaffected by input changes during a load.
- sram_we_n never falls in the same cycle that address or data change.

Test Plan:
- Basic load: base_addr=0x000100, word_count=3; FIFO preloaded with 0x21FF, 0xA5A5, 0x1234 -> SRAM word 0x100=0x21FF, 0x101=0xA5A5, 0x102=0x1234. fifo_rd pulses exactly 3 times. done pulses once, 27 cycles after WAIT_DATA entry. words_written=3, err=0.
- Starved FIFO: word_count=2, TIMEOUT=20; FIFO supplies one halfword and then stays empty -> one write to base. done and err assert after 20 empty cycles. words_written=1, all SRAM strobes end at 1.
- Zero count: start with word_count=0 -> done pulses on the cycle after start. No fifo_rd, sram_we_n never low.
- Address wrap: ADDR_W=4, base_addr=0xF, word_count=2 -> writes land at 0xF then 0x0.
- Reset mid-write: assert rst while in WRITE -> the next edge shows sram_we_n=1, sram_ce_n=1, sram_dq_oe=0, busy=0. A subsequent start proceeds normally.
- Start during busy: pulse start with different base_addr mid-load -> it is ignored; the original address sequence continues and err is unchanged.

Source files
------------

// File: rtl/uart_sram_loader.sv
// uart_sram_loader
// Drains 16-bit halfwords from the UART byte-packing FIFO and writes them to
// consecutive word addresses of a 16-bit asynchronous SRAM. The block owns the
// SRAM bus while busy and releases it (CE/UB/LB high, data undriven) at the end
// of every load, normal or aborted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load request, sampled only while idle
//   base_addr         first SRAM word address, captured on accepted start
//   word_count        halfwords to write, captured on accepted start
//   fifo_empty        FIFO holds no complete halfword
//   fifo_dout         FIFO read data, valid the cycle after fifo_rd
//   fifo_rd           one-cycle FIFO read strobe
//   sram_addr         SRAM word address
//   sram_dq_out       write data for the SRAM data pins
//   sram_dq_oe        drive sram_dq_out onto the bidirectional pins
//   sram_ce_n/we_n/oe_n/ub_n/lb_n  active-low SRAM controls
//   busy              load in progress
//   done              one-cycle pulse at the end of a load
//   err               sticky timeout flag, cleared by the next accepted start
//   words_written     halfwords committed in the current or last load
module uart_sram_loader #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned WE_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              fifo_empty,
  input  logic [15:0]       fifo_dout,
  output logic              fifo_rd,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_written
);

  // Counter widths; each counter only needs to reach its limit minus one.
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WE_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    FETCH,
    CAPTURE,
    SETUP,
    WRITE,
    HOLD,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [TO_W-1:0]   to_cnt;
  logic [WE_W-1:0]   we_cnt;

  // Sequencer: every output is set on the edge that enters the state it
  // belongs to, so the values seen during a state are that state's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      to_cnt        <= '0;
      we_cnt        <= '0;
      fifo_rd       <= 1'b0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      // Single-cycle strobes fall back unless a state raises them.
      fifo_rd <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            sram_addr     <= base_addr;
            remaining     <= word_count;
            words_written <= '0;
            err           <= 1'b0;
            busy          <= 1'b1;
            to_cnt        <= '0;
            if (word_count == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (!fifo_empty) begin
            to_cnt  <= '0;
            fifo_rd <= 1'b1;
            state   <= FETCH;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // TIMEOUT consecutive empty cycles: abort and release the bus.
            err        <= 1'b1;
            done       <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            state      <= FINISH;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        FETCH: begin
          // fifo_dout becomes valid during CAPTURE.
          state <= CAPTURE;
        end

        CAPTURE: begin
          // Data, chip and byte enables settle here; we_n stays high.
          sram_dq_out <= fifo_dout;
          sram_ce_n   <= 1'b0;
          sram_ub_n   <= 1'b0;
          sram_lb_n   <= 1'b0;
          sram_dq_oe  <= 1'b1;
          sram_we_n   <= 1'b1;
          state       <= SETUP;
        end

        SETUP: begin
          sram_we_n <= 1'b0;
          we_cnt    <= '0;
          state     <= WRITE;
        end

        WRITE: begin
          if (we_cnt == WE_W'(WE_CYCLES - 1)) begin
            sram_we_n <= 1'b1;
            state     <= HOLD;
          end else begin
            we_cnt <= we_cnt + WE_W'(1);
          end
        end

        HOLD: begin
          // we_n rose on entry; address moves only after this hold cycle.
          sram_addr     <= sram_addr + ADDR_W'(1);
          words_written <= words_written + ADDR_W'(1);
          remaining     <= remaining - ADDR_W'(1);
          if (remaining == ADDR_W'(1)) begin
            done       <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            state      <= FINISH;
          end else begin
            state <= WAIT_DATA;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_loader.sv
// Testbench for uart_sram_loader: FIFO and SRAM models, randomized loads,
// and a queue-based reference of which halfwords land at which addresses.
module tb_uart_sram_loader;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned WE_CYCLES = 4;
  localparam int unsigned TIMEOUT   = 20;
  localparam int unsigned PER_WORD  = WE_CYCLES + 5;
  localparam int unsigned MASK      = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              fifo_empty;
  logic [15:0]       fifo_dout = 16'h0;
  logic              fifo_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ub_n;
  logic              sram_lb_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] words_written;

  uart_sram_loader #(
    .ADDR_W   (ADDR_W),
    .WE_CYCLES(WE_CYCLES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n),
    .sram_ub_n    (sram_ub_n),
    .sram_lb_n    (sram_lb_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: push side owned by the stimulus, pop side by the read strobe.
  logic [15:0] fifo_mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int rd_viol  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_empty) begin
        rd_viol <= rd_viol + 1;
      end else begin
        fifo_dout <= fifo_mem[pop_cnt % 256];
        pop_cnt   <= pop_cnt + 1;
      end
    end
  end

  // SRAM pin monitor: a write commits when we_n rises with the chip selected.
  logic [ADDR_W-1:0] obs_addr [0:255];
  logic [15:0]       obs_data [0:255];
  int                obs_n     = 0;
  int                prot_viol = 0;
  logic              prev_we   = 1'b1;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [15:0]       prev_dq   = '0;

  always @(negedge clk) begin
    if (!prev_we && sram_we_n && !sram_ce_n) begin
      obs_addr[obs_n] <= sram_addr;
      obs_data[obs_n] <= sram_dq_out;
      obs_n           <= obs_n + 1;
    end
    if (prev_we && !sram_we_n && (sram_addr != prev_addr || sram_dq_out != prev_dq))
      prot_viol <= prot_viol + 1;
    if (!sram_we_n && (sram_ce_n || !sram_dq_oe || sram_ub_n || sram_lb_n || !sram_oe_n))
      prot_viol <= prot_viol + 1;
    prev_we   <= sram_we_n;
    prev_addr <= sram_addr;
    prev_dq   <= sram_dq_out;
  end

  // Reference: everything pushed and not yet consumed by a modelled load.
  logic [15:0] ref_q   [$];
  logic [15:0] stage_q [$];

  task automatic push_word(input logic [15:0] d);
    fifo_mem[push_cnt % 256] = d;
    push_cnt++;
    ref_q.push_back(d);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
    check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    check({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    check({tag, "_ublb"}, 32'({sram_ub_n, sram_lb_n}), 32'd3);
    check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
  endtask

  // One complete load. Expected timing: the load takes PER_WORD cycles per
  // halfword written, plus TIMEOUT cycles if the FIFO runs dry, and done is
  // seen on the cycle after that (counting the first cycle after start as 1).
  task automatic run_load(input int base, input int cnt, input bit poke);
    logic [15:0] exp_d [$];
    int avail, k, exp_done, limit, done_at, pulses, pop0, obs0;
    bit exp_err;
    while (stage_q.size() > 0) push_word(stage_q.pop_front());
    avail   = ref_q.size();
    k       = (cnt < avail) ? cnt : avail;
    exp_err = (cnt > avail);
    for (int i = 0; i < k; i++) exp_d.push_back(ref_q.pop_front());
    exp_done = PER_WORD * k + (exp_err ? TIMEOUT : 0) + 1;
    limit    = exp_done + 20;
    pop0 = pop_cnt;
    obs0 = obs_n;
    done_at = 0;
    pulses  = 0;

    base_addr  = ADDR_W'(base);
    word_count = ADDR_W'(cnt);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = ADDR_W'($urandom);

    for (int s = 1; s <= limit; s++) begin
      if (s == 1) check("busy_on_start", 32'(busy), 32'd1);
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = s;
      end
      if (poke && s == 12) begin
        start     = 1'b1;
        base_addr = ADDR_W'(base + 7);
      end
      if (poke && s == 13) start = 1'b0;
      if (done_at != 0 && s >= done_at + 2) break;
      @(negedge clk);
    end
    start = 1'b0;

    check("done_cycle", 32'(done_at), 32'(exp_done));
    check("done_pulses", 32'(pulses), 32'd1);
    check("err", 32'(err), 32'(exp_err));
    check("words_written", 32'(words_written), 32'(k));
    check("fifo_reads", 32'(pop_cnt - pop0), 32'(k));
    check("write_count", 32'(obs_n - obs0), 32'(k));
    for (int i = 0; i < k; i++) begin
      check("wr_addr", 32'(obs_addr[(obs0 + i) % 256]), (base + i) & MASK);
      check("wr_data", 32'(obs_data[(obs0 + i) % 256]), 32'(exp_d[i]));
    end
    check_idle_bus("post");
    if (done_at == 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Reset asserted in the middle of the first write pulse of a 2-word load.
  task automatic reset_mid_write();
    int pop0, mark, obs0;
    push_word(16'($urandom));
    push_word(16'($urandom));
    // The first halfword is fetched before the reset and then lost.
    void'(ref_q.pop_front());
    pop0 = pop_cnt;
    obs0 = obs_n;
    base_addr  = ADDR_W'($urandom);
    word_count = ADDR_W'(2);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("we_low_before_rst", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst  = 1'b0;
    mark = pop_cnt;
    repeat (6) @(negedge clk);
    check("rst_one_fetch", 32'(mark - pop0), 32'd1);
    check("rst_no_fifo_rd", 32'(pop_cnt - mark), 32'd0);
    check("rst_no_write", 32'(obs_n - obs0), 32'd0);
    check("rst_words_written", 32'(words_written), 32'd0);
  endtask

  initial begin
    int cnt, n, base;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    check("reset_fifo_rd", 32'(fifo_rd), 32'd0);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_dq", 32'(sram_dq_out), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ww", 32'(words_written), 32'd0);
    check_idle_bus("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic load with the fixed data pattern.
    stage_q = '{16'h21FF, 16'hA5A5, 16'h1234};
    run_load(32'h100, 3, 1'b0);

    // Zero count: done on the cycle after start, no FIFO or SRAM activity.
    run_load(int'($urandom & MASK), 0, 1'b0);

    // Address wrap at the top of the address space.
    stage_q = '{16'($urandom), 16'($urandom)};
    run_load(int'(MASK), 2, 1'b0);

    // Starved FIFO: one halfword then empty.
    stage_q = '{16'hBEEF};
    run_load(32'h040, 2, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    reset_mid_write();

    // Load after reset; consumes the halfword left in the FIFO first.
    stage_q = '{16'($urandom), 16'($urandom)};
    run_load(int'($urandom & MASK), 3, 1'b0);

    // Start pulse mid-load must be ignored.
    stage_q = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_load(32'h200, 4, 1'b1);

    // Randomized loads, some near the wrap point, some starved.
    for (int t = 0; t < 10; t++) begin
      cnt = int'($urandom_range(1, 4));
      n   = int'($urandom_range(cnt - 1, cnt));
      for (int i = 0; i < n; i++) stage_q.push_back(16'($urandom));
      if ($urandom_range(0, 2) == 0) base = int'(MASK) - int'($urandom_range(0, 2));
      else base = int'($urandom & MASK);
      run_load(base, cnt, 1'b0);
    end

    check("sram_protocol", 32'(prot_viol), 32'd0);
    check("fifo_rd_when_empty", 32'(rd_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
